// File: rtl/dmem_pkg.sv
// Shared definitions for the data-side memory subsystem: MMIO register
// offsets, TX_STATUS bit positions and the address region decoder.
package dmem_pkg;

    // MMIO register offsets inside the 256-byte window (word aligned)
    localparam logic [7:0] OFF_MTIME_LO    = 8'h00;
    localparam logic [7:0] OFF_MTIME_HI    = 8'h04;
    localparam logic [7:0] OFF_MTIMECMP_LO = 8'h08;
    localparam logic [7:0] OFF_MTIMECMP_HI = 8'h0C;
    localparam logic [7:0] OFF_TX_DATA     = 8'h10;
    localparam logic [7:0] OFF_TX_STATUS   = 8'h14;

    // TX_STATUS bit positions; count occupies bits [7:0]
    localparam int ST_OVERFLOW = 11;
    localparam int ST_FULL     = 10;
    localparam int ST_EMPTY    = 9;

    typedef enum logic [1:0] {
        REG_RAM  = 2'd0,
        REG_MMIO = 2'd1,
        REG_NONE = 2'd2
    } region_e;

    // RAM wins below 4*ram_words bytes; the MMIO window is one 256-byte page.
    // The compare is done at 34 bits so a 2^30-word RAM cannot overflow it.
    function automatic region_e decode_region(input logic [31:0] addr,
                                              input int unsigned ram_words,
                                              input logic [23:0] mmio_page);
        logic [33:0] ram_bytes;
        ram_bytes = 34'(ram_words) << 2;
        if ({2'b00, addr} < ram_bytes) begin
            return REG_RAM;
        end else if (addr[31:8] == mmio_page) begin
            return REG_MMIO;
        end else begin
            return REG_NONE;
        end
    endfunction

endpackage

// File: rtl/data_mem_sys_if.sv
// Bundle of the core data port and the TX byte stream.
//
// Core data port: an access happens in every cycle with ce=1; we selects
// write (1) or read (0). rdata is combinational and only meaningful for a
// read in the same cycle.
// TX stream: a byte transfers on a rising clk edge where tx_valid=1 and
// tx_ready=1; tx_valid never depends on tx_ready and tx_data is held while
// tx_valid=1 and tx_ready=0.
interface data_mem_sys_if;
    logic        ce;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    // Core plus stream consumer side
    modport master (
        output ce, we, addr, wdata, tx_ready,
        input  rdata, tx_data, tx_valid
    );

    // Memory subsystem side
    modport slave (
        input  ce, we, addr, wdata, tx_ready,
        output rdata, tx_data, tx_valid
    );
endinterface

// File: rtl/data_mem_sys_tx_fifo.sv
// Byte-wide synchronous FIFO feeding the TX stream. A push into a full FIFO
// is still accepted when the head is popped in the same cycle; otherwise it
// is dropped and the sticky overflow flag is raised. Overflow set beats clear.
module tx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop_ready,
    input  logic                     clr_overflow,
    output logic [7:0]               head,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] cnt;
    logic          pop;
    logic          push_ok;
    logic          ovf_set;

    assign empty    = (cnt == '0);
    assign full     = (cnt == CW'(DEPTH));
    assign valid    = !empty;
    assign count    = cnt;
    assign head     = mem[rd_ptr];
    assign pop      = valid && pop_ready;
    assign push_ok  = push && (!full || pop);
    assign ovf_set  = push && full && !pop;

    // Storage, pointers and occupancy; storage is cleared so tx_data is 0 out of reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Sticky overflow: a dropped push in the same cycle as a clear keeps it set
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow <= 1'b0;
        end else if (ovf_set) begin
            overflow <= 1'b1;
        end else if (clr_overflow) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: rtl/data_mem_sys.sv
// Data-side memory subsystem behind the core MEM stage: word RAM, a small
// MMIO window with a 64-bit timer and a TX byte FIFO.
// Build option: define DMEM_TIMER_EN to include mtime/mtimecmp and the timer
// interrupt; without it the timer offsets read 0 and timer_irq is tied low.
module data_mem_sys
    import dmem_pkg::*;
#(
    parameter int          DEPTH      = 1024,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
    input  logic           clk,
    input  logic           rst,
    data_mem_sys_if.slave  bus,
    output logic           timer_irq
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    region_e       region;
    logic [7:0]    offset;
    logic          rd_en;
    logic          ram_wr;
    logic          mmio_wr;
    logic [AW-1:0] ram_idx;
    logic [31:0]   ram [DEPTH];
    logic [31:0]   timer_rdata;
    logic [31:0]   tx_status;

    logic          fifo_push;
    logic          fifo_clr_ovf;
    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_overflow;

    assign region       = decode_region(bus.addr, DEPTH, MMIO_BASE[31:8]);
    assign offset       = {bus.addr[7:2], 2'b00};
    assign ram_idx      = bus.addr[AW+1:2];
    assign rd_en        = bus.ce && !bus.we;
    assign ram_wr       = bus.ce && bus.we && (region == REG_RAM);
    assign mmio_wr      = bus.ce && bus.we && (region == REG_MMIO);
    assign fifo_push    = mmio_wr && (offset == OFF_TX_DATA);
    assign fifo_clr_ovf = mmio_wr && (offset == OFF_TX_STATUS) && bus.wdata[ST_OVERFLOW];

    // RAM contents are deliberately not reset; writes land on the access edge
    always_ff @(posedge clk) begin
        if (ram_wr) begin
            ram[ram_idx] <= bus.wdata;
        end
    end

    tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk          (clk),
        .rst          (rst),
        .push         (fifo_push),
        .push_data    (bus.wdata[7:0]),
        .pop_ready    (bus.tx_ready),
        .clr_overflow (fifo_clr_ovf),
        .head         (bus.tx_data),
        .valid        (bus.tx_valid),
        .count        (fifo_count),
        .full         (fifo_full),
        .empty        (fifo_empty),
        .overflow     (fifo_overflow)
    );

    // TX_STATUS word: flags in bits 11..9, zero-extended count in bits 7..0
    always_comb begin
        tx_status              = '0;
        tx_status[7:0]         = 8'(fifo_count);
        tx_status[ST_EMPTY]    = fifo_empty;
        tx_status[ST_FULL]     = fifo_full;
        tx_status[ST_OVERFLOW] = fifo_overflow;
    end

`ifdef DMEM_TIMER_EN
    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic        irq_q;

    // Free-running mtime, compare register writes and one-cycle registered compare
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mtime    <= '0;
            mtimecmp <= '1;
            irq_q    <= 1'b0;
        end else begin
            mtime <= mtime + 64'd1;
            irq_q <= (mtime >= mtimecmp);
            if (mmio_wr && (offset == OFF_MTIMECMP_LO)) begin
                mtimecmp[31:0] <= bus.wdata;
            end
            if (mmio_wr && (offset == OFF_MTIMECMP_HI)) begin
                mtimecmp[63:32] <= bus.wdata;
            end
        end
    end

    assign timer_irq = irq_q;

    // Read mux for the four timer words
    always_comb begin
        timer_rdata = '0;
        case (offset)
            OFF_MTIME_LO:    timer_rdata = mtime[31:0];
            OFF_MTIME_HI:    timer_rdata = mtime[63:32];
            OFF_MTIMECMP_LO: timer_rdata = mtimecmp[31:0];
            OFF_MTIMECMP_HI: timer_rdata = mtimecmp[63:32];
            default:         timer_rdata = '0;
        endcase
    end
`else
    assign timer_irq   = 1'b0;
    assign timer_rdata = '0;
`endif

    // Load data: zero unless a read hits RAM or a readable MMIO register
    always_comb begin
        bus.rdata = '0;
        if (rd_en) begin
            case (region)
                REG_RAM: bus.rdata = ram[ram_idx];
                REG_MMIO: begin
                    case (offset)
                        OFF_MTIME_LO,
                        OFF_MTIME_HI,
                        OFF_MTIMECMP_LO,
                        OFF_MTIMECMP_HI: bus.rdata = timer_rdata;
                        OFF_TX_STATUS:   bus.rdata = tx_status;
                        default:         bus.rdata = '0;
                    endcase
                end
                default: bus.rdata = '0;
            endcase
        end
    end

endmodule

// File: doc/data_mem_sys.md
Name: data_mem_sys

Overview:
- Data-side memory subsystem directly downstream of the core's MEM stage. It consumes the core's data port (ce, we, addr, wdata) and returns read data in the same cycle.
- Contains a word-addressed data RAM and a small MMIO window. The window holds a 64-bit free-running timer with compare interrupt and a byte-wide transmit FIFO drained over a valid/ready stream.

Parameters:
- DEPTH, 1024, RAM size in 32-bit words; power of two.
- FIFO_DEPTH, 8, TX FIFO entries; power of two, >=2.
- MMIO_BASE, 32'hFFFF_0000, base address of the 256-byte MMIO window.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- ce  input  1  access strobe from core MEM stage.
- we  input  1  1 = write, 0 = read; valid when ce=1.
- addr  input  32  byte address; addr[1:0] ignored (word access only).
- wdata  input  32  store data.
- rdata  output  32  load data, combinational from addr/ce.
- tx_data  output  8  FIFO head byte.
- tx_valid  output  1  FIFO non-empty.
- tx_ready  input  1  consumer accepts head when tx_valid=1.
- timer_irq  output  1  registered timer interrupt.

Behaviour:
- Clock and reset: clk single clock; rst asynchronous, active-low.
- Reset values: mtime=0; mtimecmp=all ones; FIFO empty; overflow=0; timer_irq=0; tx_valid=0; tx_data=0. RAM contents are not reset.
- Decode, RAM region: addr < 4*DEPTH, index = addr[log2(DEPTH)+1:2].
- Decode, MMIO region: addr[31:8] == MMIO_BASE[31:8].
- Decode, otherwise unmapped: reads return 0, writes ignored.
- rdata = 0 when ce=0 or we=1.
- RAM read is asynchronous (0 added latency).
- RAM write takes effect at the clk edge where ce&we=1; a read of the same word in the next cycle returns new data.
- MMIO offset 0x00 MTIME_LO, RO: mtime[31:0].
- MMIO offset 0x04 MTIME_HI, RO: mtime[63:32].
- MMIO offset 0x08 MTIMECMP_LO, RW.
- MMIO offset 0x0C MTIMECMP_HI, RW.
- MMIO offset 0x10 TX_DATA, WO: push wdata[7:0]; reads 0.
- MMIO offset 0x14 TX_STATUS, RW.
  - Read: {20'b0, overflow[11], full[10], empty[9], 1'b0, count[7:0]}; count zero-extended.
  - Write with wdata[11]=1 clears overflow.
- Other MMIO offsets read 0; writes to them are ignored.
- Timer:
  - mtime increments by 1 every cycle and wraps 2^64-1 -> 0.
  - timer_irq <= (mtime >= mtimecmp), an unsigned 64-bit compare, so 1-cycle latency.
  - A write to either MTIMECMP half is visible to the compare on the following cycle.
- FIFO:
  - pop = tx_valid & tx_ready.
  - A push is accepted when count<FIFO_DEPTH, or when full and pop occurs in the same cycle (count unchanged, head advances, tail written).
  - A push when full and no pop: data dropped, overflow set (sticky).
  - Pop when empty: impossible, since tx_valid=0.
  - Simultaneous push and pop when empty: push accepted, no pop; tx_valid rises the next cycle.
  - tx_data is the registered head entry; it is stable while tx_valid=1 and tx_ready=0.
  - Pointers wrap modulo FIFO_DEPTH. Count uses log2(FIFO_DEPTH)+1 bits.
- Overflow clear and new overflow in the same cycle: set wins.
- Reset asserted mid-operation clears the FIFO and timer immediately, regardless of clk. Any in-flight write is lost.

Optional Feature:
- Macro DMEM_TIMER_EN.
- When defined: the timer exists as specified above.
- When undefined: no mtime/mtimecmp registers; offsets 0x00-0x0C read 0 and ignore writes; timer_irq tied 0.
- RAM and FIFO behaviour are identical in both builds.

Decomposition:
- Shared package dmem_pkg:
  - MMIO offset constants: OFF_MTIME_LO, OFF_MTIME_HI, OFF_MTIMECMP_LO, OFF_MTIMECMP_HI, OFF_TX_DATA, OFF_TX_STATUS.
  - TX_STATUS bit positions: ST_OVERFLOW=11, ST_FULL=10, ST_EMPTY=9.
  - Region-select enum: REG_RAM, REG_MMIO, REG_NONE.
- Sub-module tx_fifo: parameterised synchronous FIFO with push/pop, count, full/empty and a push-when-full-with-pop rule.
- Decode, RAM and timer remain in data_mem_sys.

Test Plan:
- RAM access:
  - Stimulus: write 32'hDEADBEEF to 0x0000_0040, then read 0x0000_0040 and 0x0000_0042.
  - Required: both reads give 32'hDEADBEEF; a read of 0x0001_0000 gives 0.
- Timer compare:
  - Stimulus: after reset, write MTIMECMP_HI=0, then MTIMECMP_LO=20.
  - Required: timer_irq=0 until the cycle after mtime reaches 20, then stays 1.
  - Stimulus: write MTIMECMP_LO=32'hFFFF_FFFF.
  - Required: timer_irq drops one cycle later.
- FIFO fill and overflow:
  - Stimulus: tx_ready=0; push bytes 0x01..0x09.
  - Required: TX_STATUS reads count=8, full=1, overflow=1.
  - Stimulus: raise tx_ready.
  - Required: stream delivers exactly 0x01..0x08 in order, then empty=1 and tx_valid=0.
- Full push with pop:
  - Stimulus: FIFO full, tx_ready=1; push 0xAA in the same cycle.
  - Required: count stays 8, overflow stays 0, and 0xAA is delivered eighth after the current head.
- Backpressure and clear:
  - Stimulus: toggle tx_ready randomly.
  - Required: tx_data is held stable while tx_valid=1 and tx_ready=0; no byte is lost or duplicated.
  - Stimulus: write TX_STATUS with wdata[11]=1.
  - Required: overflow reads 0.
- Asynchronous reset:
  - Stimulus: assert rst low between clk edges with 3 bytes queued and mtime=100.
  - Required: tx_valid=0, count=0, MTIME_LO=0, timer_irq=0 immediately.
  - Required: after release, mtime restarts from 0.
